// File: rtl/anemo_freq_meter.sv
// Anemometer frequency meter: sync, glitch filter, gated edge count.
// Optional ANEMO_OVERFLOW_FLAG_EN adds the saturation flag output.
module anemo_freq_meter #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int GATE_MS     = 1000,
    parameter int FILTER_LEN  = 4,
    parameter int DATA_W      = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              in_freq_anemometre,
    input  logic              continu,
    input  logic              start_stop,
    output logic [DATA_W-1:0] data_anemometre,
    output logic              data_valid,
`ifdef ANEMO_OVERFLOW_FLAG_EN
    output logic              overflow,
`endif
    output logic              busy
);

    localparam int GATE_CYCLES = CLK_FREQ_HZ / 1000 * GATE_MS;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int RW = $clog2(FILTER_LEN);
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [RW-1:0]     RUN_LAST  = RW'(FILTER_LEN - 1);
    localparam logic [DATA_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

    logic [1:0]        sync_q;
    logic              filt_q, filt_d, filt_prev_q;
    logic [RW-1:0]     run_q, run_d;
    state_t            state_q, state_d;
    logic [GW-1:0]     gate_q, gate_d;
    logic [DATA_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              edge_w;
`ifdef ANEMO_OVERFLOW_FLAG_EN
    logic              sat_q, sat_d, ovf_q, ovf_d, hit_w;
`endif

    // Filtered level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        run_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (run_q == RUN_LAST) filt_d = sync_q[1];
            else run_d = run_q + 1'b1;
        end
    end

    assign edge_w   = filt_q & ~filt_prev_q;
    assign cnt_next = (edge_w && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
`ifdef ANEMO_OVERFLOW_FLAG_EN
    assign hit_w    = edge_w && (cnt_q == CNT_MAX);
`endif

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy    = 1'b0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
        sat_d   = sat_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (continu || start_stop) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
                    sat_d   = 1'b0;
                    if (!continu) ovf_d = 1'b0;
`endif
                    if (!continu) valid_d = 1'b0;
                end
            end
            MEASURE: begin
                busy = 1'b1;
                if (gate_q == GATE_LAST) begin
                    // Window end: the edge on this cycle belongs to this window
                    data_d  = cnt_next;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    cnt_d   = '0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
                    ovf_d   = sat_q | hit_w;
                    sat_d   = 1'b0;
`endif
                    if (continu) state_d = MEASURE;
                    else if (start_stop) state_d = DONE;
                    else state_d = IDLE;
                end else begin
                    gate_d = gate_q + 1'b1;
                    cnt_d  = cnt_next;
`ifdef ANEMO_OVERFLOW_FLAG_EN
                    sat_d  = sat_q | hit_w;
`endif
                end
            end
            DONE: begin
                if (continu) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
                    sat_d   = 1'b0;
`endif
                end else if (!start_stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            run_q       <= '0;
            state_q     <= IDLE;
            gate_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
`ifdef ANEMO_OVERFLOW_FLAG_EN
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], in_freq_anemometre};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            run_q       <= run_d;
            state_q     <= state_d;
            gate_q      <= gate_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
`ifdef ANEMO_OVERFLOW_FLAG_EN
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign data_anemometre = data_q;
    assign data_valid      = valid_q;
`ifdef ANEMO_OVERFLOW_FLAG_EN
    assign overflow        = ovf_q;
`endif

endmodule

// File: tb/tb_anemo_freq_meter.sv
// Directed bench for anemo_freq_meter: two instances (nominal, 4-bit saturating).
module tb_anemo_freq_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       continu = 1'b0;
    logic       start_stop = 1'b0;
    logic [7:0] d1_data;
    logic       d1_valid, d1_busy;
    logic [3:0] d2_data;
    logic       d2_valid, d2_busy;
`ifdef ANEMO_OVERFLOW_FLAG_EN
    logic       d1_ovf, d2_ovf;
`endif

    int total = 0;
    int bad = 0;
    int ph = 0;

    always #5 clk = ~clk;

    anemo_freq_meter #(
        .CLK_FREQ_HZ(1000), .GATE_MS(100), .FILTER_LEN(4), .DATA_W(8)
    ) dut1 (
        .clk_clk(clk), .reset_reset(rst), .in_freq_anemometre(in_a),
        .continu(continu), .start_stop(start_stop),
        .data_anemometre(d1_data), .data_valid(d1_valid),
`ifdef ANEMO_OVERFLOW_FLAG_EN
        .overflow(d1_ovf),
`endif
        .busy(d1_busy)
    );

    anemo_freq_meter #(
        .CLK_FREQ_HZ(1000), .GATE_MS(100), .FILTER_LEN(2), .DATA_W(4)
    ) dut2 (
        .clk_clk(clk), .reset_reset(rst), .in_freq_anemometre(in_b),
        .continu(continu), .start_stop(start_stop),
        .data_anemometre(d2_data), .data_valid(d2_valid),
`ifdef ANEMO_OVERFLOW_FLAG_EN
        .overflow(d2_ovf),
`endif
        .busy(d2_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        in_a = v;
        repeat (n) step();
    endtask

    task automatic wave(input int n, input int per, input int hi, input bit sel);
        for (int i = 0; i < n; i++) begin
            logic v;
            v = (ph % per) < hi;
            if (sel) in_b = v;
            else in_a = v;
            ph++;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        continu = 1'b0;
        start_stop = 1'b0;
        in_a = 1'b0;
        in_b = 1'b0;
        ph = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_data", d1_data, 0);
        check("rst_valid", d1_valid, 0);
        check("rst_busy", d1_busy, 0);
        step();
        step();
        rst = 1'b0;

        // continuous, period 10
        continu = 1'b1;
        wave(100, 10, 5, 0);
        check("cont_valid_early", d1_valid, 0);
        check("cont_busy_early", d1_busy, 1);
        wave(1, 10, 5, 0);
        check("cont_valid_w1", d1_valid, 1);
        check("cont_data_w1", d1_data, 10);
        check("cont_busy_w1", d1_busy, 1);
`ifdef ANEMO_OVERFLOW_FLAG_EN
        check("cont_ovf", d1_ovf, 0);
`endif
        wave(100, 10, 5, 0);
        check("cont_data_w2", d1_data, 10);
        check("cont_valid_w2", d1_valid, 1);
        check("cont_busy_w2", d1_busy, 1);

        // single-shot, period 20
        do_reset();
        start_stop = 1'b1;
        wave(100, 20, 10, 0);
        check("ss_valid_during", d1_valid, 0);
        check("ss_busy_during", d1_busy, 1);
        wave(1, 20, 10, 0);
        check("ss_valid_end", d1_valid, 1);
        check("ss_data_end", d1_data, 5);
        check("ss_busy_end", d1_busy, 0);
        wave(1, 20, 10, 0);
        check("ss_done_valid", d1_valid, 1);
        check("ss_done_busy", d1_busy, 0);
        start_stop = 1'b0;
        wave(1, 20, 10, 0);
        check("ss_drop_valid", d1_valid, 0);
        check("ss_drop_data", d1_data, 5);

        // glitch rejection
        do_reset();
        start_stop = 1'b1;
        drive(1, 1);
        drive(0, 10);
        drive(1, 3);
        drive(0, 10);
        drive(1, 6);
        drive(0, 70);
        check("gl_valid_early", d1_valid, 0);
        drive(0, 1);
        check("gl_valid", d1_valid, 1);
        check("gl_data", d1_data, 1);

        // saturation on the 4-bit instance
        do_reset();
        start_stop = 1'b1;
        wave(101, 4, 2, 1);
        check("sat_valid", d2_valid, 1);
        check("sat_data", d2_data, 15);
        check("sat_busy", d2_busy, 0);
`ifdef ANEMO_OVERFLOW_FLAG_EN
        check("sat_ovf", d2_ovf, 1);
`endif

        // edge on window-end cycle plus continu 1->0 mid-window
        do_reset();
        continu = 1'b1;
        drive(0, 50);
        continu = 1'b0;
        drive(0, 44);
        drive(1, 6);
        check("we_valid_early", d1_valid, 0);
        check("we_busy_early", d1_busy, 1);
        drive(1, 1);
        check("we_valid", d1_valid, 1);
        check("we_data", d1_data, 1);
        check("we_busy", d1_busy, 0);
        step();
        check("we_idle_busy", d1_busy, 0);
        check("we_idle_valid", d1_valid, 1);

        // reset mid-window
        do_reset();
        continu = 1'b1;
        wave(151, 10, 5, 0);
        check("mr_pre_data", d1_data, 10);
        check("mr_pre_valid", d1_valid, 1);
        rst = 1'b1;
        #1;
        check("mr_data", d1_data, 0);
        check("mr_valid", d1_valid, 0);
        check("mr_busy", d1_busy, 0);
        step();
        step();
        rst = 1'b0;
        ph = 0;
        wave(100, 10, 5, 0);
        check("mr_valid_early", d1_valid, 0);
        wave(1, 10, 5, 0);
        check("mr_valid_after", d1_valid, 1);
        check("mr_data_after", d1_data, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
